// File: rtl/btn_evt_pkg.sv
// Shared constants for the button event scheduler: event kind codes and
// the per-button FSM state encoding.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_LONG    = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_event_fsm.sv
// One button's edge detector, press/hold/auto-repeat FSM and hold/repeat
// counter. post_o/kind_o are combinational and valid in the cycle the
// edge or count terminal is seen; the top registers them into a slot.
module btn_event_fsm
  import btn_evt_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic       post_o,
  output logic [1:0] kind_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             rise, fall;

  assign rise    = btn_i & ~btn_q;
  assign fall    = ~btn_i & btn_q;
  assign state_o = state_q;

  // Previous-level register loads even during reset, so a button held
  // through reset shows no rising edge afterwards.
  always_ff @(posedge clk) begin
    btn_q <= btn_i;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and event posting; a fall beats a count terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    post_o  = 1'b0;
    kind_o  = EVT_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          post_o  = 1'b1;
          kind_o  = EVT_PRESS;
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          post_o  = 1'b1;
          kind_o  = EVT_RELEASE;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          post_o  = 1'b1;
          kind_o  = EVT_LONG;
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (fall) begin
          post_o  = 1'b1;
          kind_o  = EVT_RELEASE;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          post_o = 1'b1;
          kind_o = EVT_REPEAT;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Turns NUM_BTN debounced button levels into one serialized event stream.
// Each button FSM posts into its own pending slot; a round-robin arbiter
// drains the slots into a valid/ready output register.
//
// Handshake: an event transfers on a cycle where evt_valid & evt_ready are
// both high. While evt_valid is high and evt_ready low, evt_id and evt_kind
// hold steady. The register reloads whenever it is empty or being drained.
module btn_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26,
  localparam int IDW          = $clog2(NUM_BTN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_db,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [IDW-1:0]       evt_id,
  output logic [1:0]           evt_kind,
  output logic                 drop_flag,
  output logic [2*NUM_BTN-1:0] dbg_state_o
);

  logic [NUM_BTN-1:0] post;
  logic [1:0]         post_kind [NUM_BTN];

  logic [NUM_BTN-1:0] slot_vld_q, slot_vld_d;
  logic [1:0]         slot_kind_q [NUM_BTN];
  logic [1:0]         slot_kind_d [NUM_BTN];
  logic               drop_q, drop_d;

  logic               evt_valid_q;
  logic [IDW-1:0]     evt_id_q;
  logic [1:0]         evt_kind_q;
  logic [IDW-1:0]     ptr_q;

  logic               load;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     ptr_next;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_event_fsm #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .CNT_W        (CNT_W)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_db[g]),
      .post_o (post[g]),
      .kind_o (post_kind[g]),
      .state_o(dbg_state_o[2*g +: 2])
    );
  end

  // Round-robin search: first pending slot at or above ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (!grant_found && slot_vld_q[(int'(ptr_q) + k) % NUM_BTN]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr_q) + k) % NUM_BTN);
      end
    end
  end

  assign load     = (!evt_valid_q || evt_ready) && grant_found;
  assign ptr_next = IDW'((int'(grant_idx) + 1) % NUM_BTN);

  // Slot update: clear on grant, write posts. A post into an occupied slot
  // either overwrites (LONG/RELEASE) or is discarded (REPEAT, and a PRESS
  // that would clobber a still-pending RELEASE); both count as drops. A
  // post into a slot being granted this cycle simply takes its place.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_kind_d = slot_kind_q;
    drop_d      = drop_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (load && grant_idx == IDW'(i)) begin
        slot_vld_d[i] = 1'b0;
      end
      if (post[i]) begin
        if (!slot_vld_q[i] || (load && grant_idx == IDW'(i))) begin
          slot_vld_d[i]  = 1'b1;
          slot_kind_d[i] = post_kind[i];
        end else if (post_kind[i] == EVT_RELEASE || post_kind[i] == EVT_LONG) begin
          slot_kind_d[i] = post_kind[i];
          drop_d         = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
    end
  end

  // Pending slots and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= '0;
      drop_q     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        slot_kind_q[i] <= EVT_PRESS;
      end
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_kind_q <= slot_kind_d;
      drop_q      <= drop_d;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_kind_q  <= EVT_PRESS;
      ptr_q       <= '0;
    end else if (load) begin
      evt_valid_q <= 1'b1;
      evt_id_q    <= grant_idx;
      evt_kind_q  <= slot_kind_q[grant_idx];
      ptr_q       <= ptr_next;
    end else if (evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_kind  = evt_kind_q;
  assign drop_flag = drop_q;

endmodule
